// File: rtl/mem_io_pkg.sv
// mem_io_pkg
// Shared definitions for the CPU memory / I/O bridge.
// - io_ofs_e     : register offsets inside the 4-word I/O window
// - ST_*         : bit positions inside the STATUS word
// - DEFAULT_IO_BASE : default base address of the I/O window
// - pack_status  : assembles the STATUS read word from its fields
package mem_io_pkg;

  typedef enum logic [1:0] {
    OFS_OUT    = 2'd0,
    OFS_STATUS = 2'd1,
    OFS_IN     = 2'd2,
    OFS_TIMER  = 2'd3
  } io_ofs_e;

  localparam int ST_OUT_FULL  = 0;
  localparam int ST_OUT_EMPTY = 1;
  localparam int ST_IN_VALID  = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 8;

  localparam logic [15:0] DEFAULT_IO_BASE = 16'hFF00;

  // Unused STATUS bits always read as zero.
  function automatic logic [15:0] pack_status(input logic       outFull,
                                              input logic       outEmpty,
                                              input logic       inValid,
                                              input logic       overflow,
                                              input logic [4:0] outCount);
    logic [15:0] s;
    s = '0;
    s[ST_OUT_FULL]                = outFull;
    s[ST_OUT_EMPTY]               = outEmpty;
    s[ST_IN_VALID]                = inValid;
    s[ST_OVERFLOW]                = overflow;
    s[ST_COUNT_MSB:ST_COUNT_LSB]  = outCount;
    return s;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo
// Single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk_i, reset_i      : clock and synchronous reset (empties the FIFO)
//   push_i, wdata_i     : write request and data
//   pop_i               : read request (head advances)
//   rdata_o             : current head entry (valid when !empty_o)
//   full_o, empty_o     : occupancy flags
//   count_o             : number of stored entries, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A pop frees a slot in the same cycle, so push-when-full succeeds if a pop
  // accompanies it.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and storage; reset only clears the bookkeeping, which discards
  // whatever the array holds.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= wdata_i;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge
// Sits between the CPU memory port and an external synchronous block RAM,
// carving a 4-word memory-mapped I/O window out of the address space.
// Ports:
//   Clock, Reset            : clock, synchronous active-high reset
//   Mem_Addr/Mem_Write/Data_Out : CPU address, write enable, write data
//   Mem_Data                : read data, valid one cycle after the address
//   ram_addr/ram_we/ram_wdata/ram_rdata : block RAM port (1-cycle read)
//   io_out_data/io_out_valid/io_out_ready : output stream (FIFO head)
//   io_in_data/io_in_valid/io_in_ready    : input stream (one-entry latch)
// I/O window (IO_BASE + n): 0 OUT, 1 STATUS, 2 IN, 3 reserved / cycle timer.
// Optional feature macro: MEM_IO_BRIDGE_CYCLE_TIMER_EN maps a free-running
// 16-bit cycle counter at IO_BASE+3.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int          OUT_DEPTH = 8,
  parameter logic [15:0] IO_BASE   = DEFAULT_IO_BASE,
  parameter int          RAM_AW    = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       Mem_Addr,
  input  logic              Mem_Write,
  input  logic [15:0]       Data_Out,
  output logic [15:0]       Mem_Data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       io_out_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  input  logic [15:0]       io_in_data,
  input  logic              io_in_valid,
  output logic              io_in_ready
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic [15:0]   ioOffset;
  logic          ioHit;
  io_ofs_e       ioOfs;
  logic          sameAsPrev;
  logic          outPush, outPop, pushDrop, inPop, statusWr;
  logic          outFull, outEmpty;
  logic [CW-1:0] outCount;
  logic [15:0]   statusWord, ioRdData;

  logic          sel_q;
  logic [15:0]   ioRd_q;
  logic [15:0]   prevAddr_q;
  logic          prevWrite_q;
  logic          overflow_q, overflow_d;
  logic          inValid_q, inValid_d;
  logic [15:0]   inData_q, inData_d;

  // Subtracting the base lets the window sit at any alignment.
  assign ioOffset = Mem_Addr - IO_BASE;
  assign ioHit    = (ioOffset[15:2] == 14'd0);
  assign ioOfs    = io_ofs_e'(ioOffset[1:0]);

  assign ram_addr  = Mem_Addr[RAM_AW-1:0];
  assign ram_wdata = Data_Out;
  assign ram_we    = Mem_Write & ~ioHit;

  // The CPU can hold one access for several cycles; only the first cycle of
  // such a run may push or pop.
  assign sameAsPrev = (Mem_Addr == prevAddr_q) && (Mem_Write == prevWrite_q);
  assign outPush    = ioHit && (ioOfs == OFS_OUT) && Mem_Write && !sameAsPrev;
  assign inPop      = ioHit && (ioOfs == OFS_IN) && !Mem_Write && !sameAsPrev;
  assign statusWr   = ioHit && (ioOfs == OFS_STATUS) && Mem_Write;

  assign io_out_valid = ~outEmpty;
  assign outPop       = io_out_valid & io_out_ready;
  assign pushDrop     = outPush & outFull & ~outPop;
  assign io_in_ready  = ~inValid_q;

  io_sync_fifo #(
    .WIDTH(16),
    .DEPTH(OUT_DEPTH)
  ) u_outFifo (
    .clk_i   (Clock),
    .reset_i (Reset),
    .push_i  (outPush),
    .wdata_i (Data_Out),
    .pop_i   (outPop),
    .rdata_o (io_out_data),
    .full_o  (outFull),
    .empty_o (outEmpty),
    .count_o (outCount)
  );

  assign statusWord = pack_status(outFull, outEmpty, inValid_q, overflow_q,
                                  5'(outCount));

`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
  logic [15:0] timer_q, timer_d;

  // Free-running counter; a CPU write to its address reloads it.
  always_comb begin
    timer_d = timer_q + 16'd1;
    if (ioHit && (ioOfs == OFS_TIMER) && Mem_Write) begin
      timer_d = Data_Out;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // Value the I/O window presents for the current address; it is registered
  // so I/O reads have the same one-cycle latency as the RAM.
  always_comb begin
    ioRdData = '0;
    if (ioHit) begin
      case (ioOfs)
        OFS_STATUS: ioRdData = statusWord;
        OFS_IN:     ioRdData = inValid_q ? inData_q : 16'h0000;
`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
        OFS_TIMER:  ioRdData = timer_q;
`else
        OFS_TIMER:  ioRdData = 16'h0000;
`endif
        default:    ioRdData = 16'h0000;
      endcase
    end
  end

  // Sticky overflow and the input latch. A CPU pop wins over a producer
  // load, so the latch refills one cycle after being read.
  always_comb begin
    overflow_d = overflow_q;
    if (statusWr) begin
      overflow_d = 1'b0;
    end else if (pushDrop) begin
      overflow_d = 1'b1;
    end

    inValid_d = inValid_q;
    inData_d  = inData_q;
    if (inPop) begin
      inValid_d = 1'b0;
    end else if (io_in_valid && io_in_ready) begin
      inValid_d = 1'b1;
      inData_d  = io_in_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_q       <= 1'b0;
      ioRd_q      <= '0;
      prevAddr_q  <= '0;
      prevWrite_q <= 1'b0;
      overflow_q  <= 1'b0;
      inValid_q   <= 1'b0;
      inData_q    <= '0;
    end else begin
      sel_q       <= ioHit;
      ioRd_q      <= ioRdData;
      prevAddr_q  <= Mem_Addr;
      prevWrite_q <= Mem_Write;
      overflow_q  <= overflow_d;
      inValid_q   <= inValid_d;
      inData_q    <= inData_d;
    end
  end

  assign Mem_Data = sel_q ? ioRd_q : ram_rdata;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge
// Drives mem_io_bridge with a table of directed cycles, a few hand-written
// multi-cycle sequences and a randomized run, comparing against a
// transaction-level model (queue FIFO, latch variable, memory array).
module tb_mem_io_bridge;

  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Mem_Addr, Data_Out, Mem_Data;
  logic        Mem_Write;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  bit   [15:0] ram_rdata;
  logic [15:0] io_out_data, io_in_data;
  logic        io_out_valid, io_out_ready, io_in_valid, io_in_ready;

  int tests = 0;
  int fails = 0;

  mem_io_bridge #(
    .OUT_DEPTH(DEPTH),
    .IO_BASE(16'hFF00),
    .RAM_AW(12)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Mem_Addr     (Mem_Addr),
    .Mem_Write    (Mem_Write),
    .Data_Out     (Data_Out),
    .Mem_Data     (Mem_Data),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .io_out_data  (io_out_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_in_data   (io_in_data),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready)
  );

  always #5 Clock = ~Clock;

  // External synchronous block RAM, read-before-write.
  bit [15:0] ramMem [4096];
  always @(posedge Clock) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  // Reference model state.
  bit   [15:0] modelRam [4096];
  logic [15:0] fq[$];
  bit          ovf, inV, prevW;
  logic [15:0] inD, prevA, expMd;
`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
  logic [15:0] mTimer;
`endif

  typedef struct {
    logic [15:0] addr;
    bit          we;
    logic [15:0] wdata;
    bit          rdy;
    bit          iv;
    logic [15:0] idata;
    bit          chk;
    logic [15:0] md;
  } vec_t;
  vec_t vecs[$];

  logic [15:0] pool [10];
  logic [15:0] rA, rD, rId;
  bit          rW, rRdy, rIv;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [15:0] modelStatus();
    logic [15:0] s;
    s = '0;
    s[0]   = (fq.size() == DEPTH);
    s[1]   = (fq.size() == 0);
    s[2]   = inV;
    s[3]   = ovf;
    s[8:4] = 5'(fq.size());
    return s;
  endfunction

  task automatic addVec(input logic [15:0] a, input bit w, input logic [15:0] d,
                        input bit rdy, input bit iv, input logic [15:0] id,
                        input bit chk, input logic [15:0] md);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.rdy = rdy;
    v.iv = iv; v.idata = id; v.chk = chk; v.md = md;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    Reset = 1'b1; Mem_Addr = 16'h0000; Mem_Write = 1'b0; Data_Out = 16'h0000;
    io_out_ready = 1'b0; io_in_valid = 1'b0; io_in_data = 16'h0000;
    @(posedge Clock); #1;
    Reset = 1'b0;
    fq.delete();
    ovf = 0; inV = 0; inD = '0; prevA = '0; prevW = 0;
`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
    mTimer = '0;
`endif
  endtask

  // One CPU cycle: drive, check combinational outputs, advance the model,
  // clock, then check the read data that belongs to this cycle's address.
  task automatic applyStimulus(input logic [15:0] a, input bit w, input logic [15:0] d,
                               input bit rdy, input bit iv, input logic [15:0] id);
    logic [15:0] ofs, rdv;
    bit hit, first, outPop;
    Mem_Addr = a; Mem_Write = w; Data_Out = d;
    io_out_ready = rdy; io_in_valid = iv; io_in_data = id;
    #1;
    hit = (a >= 16'hFF00) && (a <= 16'hFF03);
    ofs = a - 16'hFF00;
    checkBit("ram_we", ram_we, w && !hit);
    check("ram_addr", {4'h0, ram_addr}, {4'h0, a[11:0]});
    check("ram_wdata", ram_wdata, d);
    checkBit("out_valid", io_out_valid, fq.size() != 0);
    if (fq.size() != 0) check("out_data", io_out_data, fq[0]);
    checkBit("in_ready", io_in_ready, !inV);

    first = !(a == prevA && w == prevW);
    rdv = 16'h0000;
    if (hit) begin
      case (ofs[1:0])
        2'd1: rdv = modelStatus();
        2'd2: rdv = inV ? inD : 16'h0000;
        2'd3: begin
`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
          rdv = mTimer;
`endif
        end
        default: rdv = 16'h0000;
      endcase
    end
    expMd = hit ? rdv : modelRam[a[11:0]];

    outPop = (fq.size() != 0) && rdy;
    if (outPop) void'(fq.pop_front());
    if (hit && ofs == 16'd0 && w && first) begin
      if (fq.size() < DEPTH) fq.push_back(d);
      else ovf = 1;
    end
    if (hit && ofs == 16'd1 && w) ovf = 0;
    if (hit && ofs == 16'd2 && !w && first) inV = 0;
    else if (iv && !inV) begin
      inV = 1;
      inD = id;
    end
    if (w && !hit) modelRam[a[11:0]] = d;
`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
    if (hit && ofs == 16'd3 && w) mTimer = d;
    else mTimer = mTimer + 16'd1;
`endif
    prevA = a;
    prevW = w;

    @(posedge Clock); #1;
    if (!w) check("mem_data", Mem_Data, expMd);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    check(name, Mem_Data, exp);
  endtask

  initial begin
    // Directed table: RAM round trip, FIFO overflow, STATUS clear, input latch.
    addVec(16'h0010, 1, 16'hBEEF, 0, 0, 0, 0, 0);
    addVec(16'h0010, 0, 16'h0000, 0, 0, 0, 1, 16'hBEEF);
    for (int v = 1; v <= 9; v++) begin
      for (int h = 0; h < 3; h++) addVec(16'hFF00, 1, 16'(v), 0, 0, 0, 0, 0);
      addVec(16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    end
    addVec(16'hFF01, 0, 16'h0000, 0, 0, 0, 1, 16'h0089);
    addVec(16'hFF01, 1, 16'h5555, 0, 0, 0, 0, 0);
    addVec(16'hFF01, 0, 16'h0000, 0, 0, 0, 1, 16'h0081);
    addVec(16'h0000, 0, 16'h0000, 0, 1, 16'h1234, 0, 0);
    addVec(16'hFF02, 0, 16'h0000, 0, 0, 0, 1, 16'h1234);
    for (int h = 0; h < 3; h++) addVec(16'hFF02, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);
    addVec(16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    addVec(16'hFF02, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);

    doReset();
    checkBit("reset_out_valid", io_out_valid, 1'b0);
    checkBit("reset_in_ready", io_in_ready, 1'b1);
    checkOutput("reset_mem_data", modelRam[0]);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata,
                    vecs[i].rdy, vecs[i].iv, vecs[i].idata);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), vecs[i].md);
    end

    // Drain three entries with the consumer always ready.
    doReset();
    for (int v = 1; v <= 3; v++) begin
      applyStimulus(16'hFF00, 1, 16'(v), 0, 0, 0);
      applyStimulus(16'h0000, 0, 16'h0000, 0, 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      check("drain_head", io_out_data, 16'(k + 1));
      applyStimulus(16'h0000, 0, 16'h0000, 1, 0, 0);
    end
    checkBit("drain_empty", io_out_valid, 1'b0);
    applyStimulus(16'hFF01, 0, 16'h0000, 0, 0, 0);
    checkOutput("drain_status", 16'h0002);

    // Full FIFO: push and consumer pop together keep count at 8, no overflow.
    doReset();
    for (int v = 0; v < DEPTH; v++) begin
      applyStimulus(16'hFF00, 1, 16'(16'h0010 + v), 0, 0, 0);
      applyStimulus(16'h0000, 0, 16'h0000, 0, 0, 0);
    end
    applyStimulus(16'hFF00, 1, 16'h0099, 1, 0, 0);
    applyStimulus(16'hFF01, 0, 16'h0000, 0, 0, 0);
    checkOutput("full_pushpop_status", 16'h0081);

    // Reset mid-stream discards the FIFO and the input latch.
    doReset();
    for (int v = 0; v < 5; v++) begin
      applyStimulus(16'hFF00, 1, 16'(16'h0A00 + v), 0, 0, 0);
      applyStimulus(16'h0000, 0, 16'h0000, 0, 0, 0);
    end
    applyStimulus(16'h0000, 0, 16'h0000, 0, 1, 16'hABCD);
    checkBit("pre_reset_in_ready", io_in_ready, 1'b0);
    doReset();
    checkBit("midreset_out_valid", io_out_valid, 1'b0);
    checkBit("midreset_in_ready", io_in_ready, 1'b1);
    applyStimulus(16'hFF01, 0, 16'h0000, 0, 0, 0);
    checkOutput("midreset_status", 16'h0002);

`ifdef MEM_IO_BRIDGE_CYCLE_TIMER_EN
    // Loaded at the write's edge, then incremented at each of the 9 edges
    // before the read address is sampled.
    doReset();
    applyStimulus(16'hFF03, 1, 16'h00FF, 0, 0, 0);
    for (int k = 0; k < 9; k++) applyStimulus(16'h0000, 0, 16'h0000, 0, 0, 0);
    applyStimulus(16'hFF03, 0, 16'h0000, 0, 0, 0);
    checkOutput("timer_read", 16'h0108);
`endif

    // Randomized traffic, including held accesses and window boundaries.
    pool[0] = 16'h0010; pool[1] = 16'hFF00; pool[2] = 16'hFF00; pool[3] = 16'hFF01;
    pool[4] = 16'hFF02; pool[5] = 16'hFF02; pool[6] = 16'hFF03; pool[7] = 16'hFEFF;
    pool[8] = 16'hFF04; pool[9] = 16'h1010;
    doReset();
    rA = 16'h0000; rW = 0; rD = 16'h0000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) >= 4) begin
        rA = pool[$urandom_range(0, 9)];
        rW = ($urandom_range(0, 1) == 1);
        rD = 16'($urandom);
      end
      rRdy = ($urandom_range(0, 9) < 3);
      rIv  = ($urandom_range(0, 1) == 1);
      rId  = 16'($urandom);
      applyStimulus(rA, rW, rD, rRdy, rIv, rId);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
